// File: rtl/isa_pkg.sv
// Shared ISA constants and the fetch FSM state type for the fetch stage.
package isa_pkg;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_JUMP = 4'b1110;
  localparam logic [3:0] OP_BRGE = 4'b1111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: redirect target, local JUMP target or pc+1.
module fetch_next_pc #(
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [3:0]        opcode,
  input  logic [7:0]        imm,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] next_pc
);
  import isa_pkg::*;

  localparam int SW = ADDR_W + 8;

  logic [SW-1:0]     off_ext;
  logic [SW-1:0]     pc_ext;
  logic [SW-1:0]     jump_sum;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] jump_pc;

  // Add at a width covering both operands, then keep the low ADDR_W bits.
  assign off_ext  = {{ADDR_W{imm[7]}}, imm};
  assign pc_ext   = {8'b0, pc};
  assign jump_sum = pc_ext + SW'(1) + off_ext;
  assign jump_pc  = jump_sum[ADDR_W-1:0];
  assign seq_pc   = pc + ADDR_W'(1);

  always_comb begin
    next_pc = seq_pc;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (opcode == OP_JUMP) begin
      next_pc = jump_pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, instruction register, local JUMP resolution.
// Optional self-jump halt enabled by defining FETCH_HALT_EN.
module instr_fetch #(
  parameter int          ADDR_W   = 6,
  parameter int          INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0]  mem_raddr,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);
  import isa_pkg::*;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;

  assign mem_raddr = pc;

  fetch_next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc             (pc),
    .opcode         (mem_rdata[OPC_MSB:OPC_LSB]),
    .imm            (mem_rdata[IMM_MSB:IMM_LSB]),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc        (next_pc)
  );

`ifdef FETCH_HALT_EN
  logic halt_q;
  assign halted = halt_q;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= ADDR_W'(RESET_PC);
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      fetch_count <= '0;
      state       <= ST_BOOT;
`ifdef FETCH_HALT_EN
      halt_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (redirect_valid) begin
            pc       <= next_pc;
            ir_valid <= 1'b0;
          end else if (!stall) begin
            ir       <= mem_rdata;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            pc       <= next_pc;
            if (fetch_count != '1) begin
              fetch_count <= fetch_count + CNT_W'(1);
            end
`ifdef FETCH_HALT_EN
            // A JUMP landing on itself is delivered, then fetch stops.
            if (mem_rdata[OPC_MSB:OPC_LSB] == OP_JUMP && next_pc == pc) begin
              state <= ST_HALT;
            end
`endif
          end
        end
`ifdef FETCH_HALT_EN
        ST_HALT: begin
          ir_valid <= 1'b0;
          halt_q   <= 1'b1;
        end
`endif
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a reference fetch model pushes expected outputs per cycle.
module tb_instr_fetch;

  localparam int AW = 6;
  localparam int IW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [IW-1:0] mem_rdata;
  logic [AW-1:0] mem_raddr;
  logic [IW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          halted;
  logic [CW-1:0] fetch_count;

  logic [IW-1:0] mem [64];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          valid;
    logic          halted;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: 0 boot, 1 run, 2 halt.
  int            m_state;
  int            m_pc;
  logic [IW-1:0] m_ir;
  int            m_ir_pc;
  logic          m_valid;
  logic          m_halted;
  int            m_cnt;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_raddr];

  instr_fetch #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .RESET_PC (0),
    .CNT_W    (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_rdata      (mem_rdata),
    .mem_raddr      (mem_raddr),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_step();
    logic [IW-1:0]     instr;
    logic signed [7:0] off;
    int                tgt;
    exp_t              e;
    if (reset) begin
      m_state = 0; m_pc = 0; m_ir = '0; m_ir_pc = 0;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (redirect_valid) begin
        m_pc = int'(redirect_pc);
        m_valid = 1'b0;
      end else if (!stall) begin
        instr = mem[m_pc];
        m_ir = instr;
        m_ir_pc = m_pc;
        m_valid = 1'b1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (instr[15:12] == 4'hE) begin
          off = instr[7:0];
          tgt = (m_pc + 1 + int'(off)) & 63;
        end else begin
          tgt = (m_pc + 1) & 63;
        end
`ifdef FETCH_HALT_EN
        if (instr[15:12] == 4'hE && tgt == m_pc) m_state = 2;
`endif
        m_pc = tgt;
      end
    end else begin
      m_valid = 1'b0;
      m_halted = 1'b1;
    end
    e.pc = AW'(m_pc); e.ir = m_ir; e.ir_pc = AW'(m_ir_pc);
    e.valid = m_valid; e.halted = m_halted; e.cnt = CW'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("raddr",    32'(mem_raddr),   32'(e.pc));
    check("ir",       32'(ir),          32'(e.ir));
    check("ir_pc",    32'(ir_pc),       32'(e.ir_pc));
    check("ir_valid", 32'(ir_valid),    32'(e.valid));
    check("halted",   32'(halted),      32'(e.halted));
    check("count",    32'(fetch_count), 32'(e.cnt));
  endtask

  task automatic redirect_to(input logic [AW-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    cycle();
    cycle();
    reset = 1'b0;

    cycle();
    check("boot_valid", 32'(ir_valid), 32'd0);
    check("boot_raddr", 32'(mem_raddr), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("seq_raddr", 32'(mem_raddr), 32'(i));
      check("seq_ir_pc", 32'(ir_pc), 32'(i - 1));
      check("seq_count", 32'(fetch_count), 32'(i));
    end

    mem[1]  = 16'hE01E;
    mem[48] = 16'hE0F4;
    redirect_to(6'd0);
    check("redir0_valid", 32'(ir_valid), 32'd0);
    check("redir0_raddr", 32'(mem_raddr), 32'd0);
    cycle();
    cycle();
    check("jump_ir",    32'(ir), 32'hE01E);
    check("jump_ir_pc", 32'(ir_pc), 32'd1);
    check("jump_raddr", 32'(mem_raddr), 32'd32);

    n = 0;
    while (mem_raddr !== 6'd48 && n < 40) begin cycle(); n++; end
    check("wait_48", 32'(mem_raddr), 32'd48);
    cycle();
    check("jump_back_raddr", 32'(mem_raddr), 32'd37);
    check("sat_count", 32'(fetch_count), 32'd15);

    redirect_to(6'd51);
    check("br_valid", 32'(ir_valid), 32'd0);
    check("br_raddr", 32'(mem_raddr), 32'd51);
    cycle();
    check("br_ir_pc", 32'(ir_pc), 32'd51);
    check("br_valid2", 32'(ir_valid), 32'd1);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_raddr", 32'(mem_raddr), 32'd52);
      check("stall_ir_pc", 32'(ir_pc), 32'd51);
    end
    redirect_to(6'd10);
    check("stall_redir_raddr", 32'(mem_raddr), 32'd10);
    check("stall_redir_valid", 32'(ir_valid), 32'd0);
    stall = 1'b0;
    cycle();

    redirect_to(6'd63);
    check("wrap_raddr63", 32'(mem_raddr), 32'd63);
    cycle();
    check("wrap_raddr0", 32'(mem_raddr), 32'd0);
    check("wrap_ir_pc", 32'(ir_pc), 32'd63);

    mem[2] = 16'hE0C0;
    redirect_to(6'd2);
    cycle();
    check("neg_jump_ir", 32'(ir), 32'hE0C0);
    check("neg_jump_raddr", 32'(mem_raddr), 32'd3);

    mem[51] = 16'hE0FF;
    redirect_to(6'd51);
    cycle();
    check("self_ir", 32'(ir), 32'hE0FF);
    check("self_valid", 32'(ir_valid), 32'd1);
    check("self_raddr", 32'(mem_raddr), 32'd51);
`ifdef FETCH_HALT_EN
    cycle();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_valid", 32'(ir_valid), 32'd0);
    check("halt_raddr", 32'(mem_raddr), 32'd51);
    redirect_to(6'd5);
    check("halt_redir_raddr", 32'(mem_raddr), 32'd51);
    check("halt_redir_halted", 32'(halted), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("unhalt_halted", 32'(halted), 32'd0);
    check("unhalt_raddr", 32'(mem_raddr), 32'd0);
`else
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("loop_raddr", 32'(mem_raddr), 32'd51);
      check("loop_valid", 32'(ir_valid), 32'd1);
      check("loop_halted", 32'(halted), 32'd0);
    end
`endif
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
